mem_port: RTL

- Multi-cycle load/store unit between the CPU datapath/control and external word-organised memory.
- Replaces the single-cycle, always-ready memory assumption with a ready handshake, per-lane byte strobes, a wait-state timeout and error reporting.
- Handles sub-word access: byte-lane select on both sides, plus sign/zero extension on loads.
- Address width is parametrised.

---
 rtl/mem_port.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port.sv
// ============================================================================
//  Module   : mem_port
//  Purpose  : Multi-cycle load/store unit between the CPU and a word-organised
//             memory. It uses a ready handshake, per-lane byte strobes, a
//             wait-state timeout, sub-word lane placement and sign/zero
//             extension on loads.
//  Ports    : clk, reset (async, active-low)
//             CPU side : req_rd, req_wr, read_op[2:0], write_op[1:0],
//                        addr_in[ADDR_W], wdata_in[32] -> busy, done,
//                        err[2], rdata_out[32]
//             Mem side : mem_addr[ADDR_W-2], mem_re, mem_we, mem_wstrb[4],
//                        mem_wdata[32] <- mem_rdata[32], mem_ready
//  Option   : MEM_PORT_MISALIGNED_SPLIT_EN - misaligned accesses that cross a
//             word boundary run as two beats instead of faulting.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [2:0]        read_op,
    input  logic [1:0]        write_op,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [31:0]       rdata_out,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [1:0] c_ERR_OK       = 2'b00;
    localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] c_ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_is_wr;
    logic [2:0]         r_rop;
    logic [1:0]         r_off;
    logic               r_split;
    logic [3:0]         r_strb_hi;   // strobes for the second beat of a split
    logic [31:0]        r_wdata_hi;  // store lanes for the second beat
    logic [31:0]        r_rbuf;      // read word captured in the first beat
    logic [WAIT_W-1:0]  r_wait;

    logic [3:0]  w_rd_mask, w_wr_mask, w_mask;
    logic        w_rd_legal, w_wr_legal, w_illegal, w_misalign;
    logic        w_misalign_fault, w_split;
    logic [7:0]  w_strb8;
    logic [31:0] w_wdata_m;
    logic [63:0] w_wdata64;
    logic [63:0] w_rdata64;
    logic [31:0] w_rlane;
    logic [31:0] w_rext;

    // Request decode: access size as a byte mask, legality and alignment.
    // Store data and strobes are laid out over an 8-lane (two word) window so
    // the same shift serves both the aligned and the word-crossing case.
    always_comb begin
        w_rd_mask  = 4'b0000;
        w_rd_legal = 1'b1;
        case (read_op)
            3'b000, 3'b100: w_rd_mask = 4'b0001;
            3'b001, 3'b101: w_rd_mask = 4'b0011;
            3'b010:         w_rd_mask = 4'b1111;
            default:        w_rd_legal = 1'b0;
        endcase

        w_wr_mask  = 4'b0000;
        w_wr_legal = 1'b1;
        case (write_op)
            2'b01:   w_wr_mask = 4'b0001;
            2'b10:   w_wr_mask = 4'b0011;
            2'b11:   w_wr_mask = 4'b1111;
            default: w_wr_legal = 1'b0;
        endcase

        w_mask     = req_wr ? w_wr_mask : w_rd_mask;
        w_illegal  = (req_rd && req_wr) || (req_rd && !w_rd_legal) ||
                     (req_wr && !w_wr_legal);
        w_misalign = ((w_mask == 4'b0011) && addr_in[0]) ||
                     ((w_mask == 4'b1111) && (addr_in[1:0] != 2'b00));

        w_strb8   = {4'b0000, w_mask} << addr_in[1:0];
        w_wdata_m = wdata_in & {{8{w_mask[3]}}, {8{w_mask[2]}},
                                {8{w_mask[1]}}, {8{w_mask[0]}}};
        w_wdata64 = {32'b0, w_wdata_m} << {addr_in[1:0], 3'b000};

`ifdef MEM_PORT_MISALIGNED_SPLIT_EN
        w_misalign_fault = 1'b0;
        w_split          = w_misalign && (w_strb8[7:4] != 4'b0000);
`else
        w_misalign_fault = w_misalign;
        w_split          = 1'b0;
`endif
    end

    // Load path: in the second beat the two words are joined so the
    // requested bytes can be pulled out with a single right shift.
    always_comb begin
        w_rdata64 = (r_state == S_BEAT1) ? {mem_rdata, r_rbuf} : {32'b0, mem_rdata};
        w_rlane   = 32'(w_rdata64 >> {r_off, 3'b000});
        case (r_rop)
            3'b000:  w_rext = {{24{w_rlane[7]}},  w_rlane[7:0]};
            3'b001:  w_rext = {{16{w_rlane[15]}}, w_rlane[15:0]};
            3'b100:  w_rext = {24'b0, w_rlane[7:0]};
            3'b101:  w_rext = {16'b0, w_rlane[15:0]};
            default: w_rext = w_rlane;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_is_wr    <= 1'b0;
            r_rop      <= 3'b000;
            r_off      <= 2'b00;
            r_split    <= 1'b0;
            r_strb_hi  <= 4'b0000;
            r_wdata_hi <= 32'b0;
            r_rbuf     <= 32'b0;
            r_wait     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= c_ERR_OK;
            rdata_out  <= 32'b0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_rd || req_wr) begin
                        r_is_wr <= req_wr;
                        r_rop   <= read_op;
                        r_off   <= addr_in[1:0];
                        busy    <= 1'b1;
                        if (w_illegal || w_misalign_fault) begin
                            r_state   <= S_RESP;
                            done      <= 1'b1;
                            err       <= w_illegal ? c_ERR_ILLEGAL : c_ERR_MISALIGN;
                            rdata_out <= 32'b0;
                        end else begin
                            r_state    <= S_BEAT0;
                            r_split    <= w_split;
                            r_strb_hi  <= req_wr ? w_strb8[7:4] : 4'b0000;
                            r_wdata_hi <= w_wdata64[63:32];
                            r_wait     <= '0;
                            mem_addr   <= addr_in[ADDR_W-1:2];
                            mem_re     <= req_rd;
                            mem_we     <= req_wr;
                            mem_wstrb  <= req_wr ? w_strb8[3:0] : 4'b0000;
                            mem_wdata  <= w_wdata64[31:0];
                        end
                    end
                end

                S_BEAT0, S_BEAT1: begin
                    if (mem_ready) begin
                        if ((r_state == S_BEAT0) && r_split) begin
                            // Strobes stay asserted; only address and lanes move on.
                            r_state   <= S_BEAT1;
                            r_rbuf    <= mem_rdata;
                            r_wait    <= '0;
                            mem_addr  <= mem_addr + 1'b1;
                            mem_wstrb <= r_strb_hi;
                            mem_wdata <= r_wdata_hi;
                        end else begin
                            r_state   <= S_RESP;
                            done      <= 1'b1;
                            err       <= c_ERR_OK;
                            rdata_out <= r_is_wr ? 32'b0 : w_rext;
                            mem_re    <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_wstrb <= 4'b0000;
                            mem_wdata <= 32'b0;
                        end
                    end else if (r_wait == c_WAIT_LAST) begin
                        // MAX_WAIT consecutive cycles without ready: abort.
                        r_state   <= S_RESP;
                        done      <= 1'b1;
                        err       <= c_ERR_TIMEOUT;
                        rdata_out <= 32'b0;
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        mem_wdata <= 32'b0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
